// File: rtl/bsg_gateway_tag_pkg.sv
// Shared types and frame-layout helpers for the gateway tag packet transmitter.
package bsg_gateway_tag_pkg;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_SEND = 2'd2,
      ST_GAP  = 2'd3
   } tag_tx_state_e;

   localparam int unsigned START_WIDTH        = 32'd1;
   localparam int unsigned DNR_WIDTH          = 32'd1;
   localparam int unsigned HEADER_FIXED_WIDTH = START_WIDTH + DNR_WIDTH;

   function automatic int unsigned frame_bits(input int unsigned node_id_width,
                                              input int unsigned len_width,
                                              input int unsigned len);
      return HEADER_FIXED_WIDTH + node_id_width + len_width + len;
   endfunction

endpackage

// File: rtl/bsg_gateway_tag_bit_timer.sv
// Bit-period down-counter; pulses o_bit_advance once every bit_cycles_p enabled cycles.
module bsg_gateway_tag_bit_timer #(
   parameter int unsigned bit_cycles_p = 1
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_restart,
   input  logic i_enable,
   output logic o_bit_advance
);

   localparam int unsigned      CNT_W    = (bit_cycles_p > 32'd1) ? $clog2(bit_cycles_p) : 32'd1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(bit_cycles_p - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   logic [CNT_W-1:0] r_cnt;

   // Reload on packet accept so the start bit gets a full period.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= CNT_ZERO;
      end else if (i_restart) begin
         r_cnt <= CNT_LOAD;
      end else if (i_enable) begin
         r_cnt <= (r_cnt == CNT_ZERO) ? CNT_LOAD : (r_cnt - CNT_W'(1));
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_bit_advance = i_enable & (r_cnt == CNT_ZERO);

endmodule

// File: rtl/bsg_gateway_tag_packet_tx.sv
// Serialises bsg_tag packets onto the ASIC TDI/TMS pins: ring-reset preamble,
// then one LSB-first frame per valid/ready handshake followed by an idle gap.
module bsg_gateway_tag_packet_tx
   import bsg_gateway_tag_pkg::*;
#(
   parameter int unsigned node_id_width_p = 5,
   parameter int unsigned len_width_p     = 6,
   parameter int unsigned payload_width_p = 36,
   parameter int unsigned reset_cycles_p  = 64,
   parameter int unsigned gap_cycles_p    = 2,
   parameter int unsigned bit_cycles_p    = 1
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       v_i,
   input  logic [node_id_width_p-1:0] node_id_i,
   input  logic                       data_not_reset_i,
   input  logic [len_width_p-1:0]     len_i,
   input  logic [payload_width_p-1:0] payload_i,
   output logic                       ready_o,
   output logic                       tag_tdi_o,
   output logic                       tag_tms_o,
   output logic                       busy_o,
   output logic                       init_done_o,
   output logic [15:0]                pkt_count_o
);

   localparam int unsigned FRAME_W = HEADER_FIXED_WIDTH + node_id_width_p + len_width_p + payload_width_p;
   localparam int unsigned TOT_W   = $clog2(FRAME_W + 32'd1);
   localparam int unsigned INIT_W  = (reset_cycles_p > 32'd1) ? $clog2(reset_cycles_p) : 32'd1;
   localparam int unsigned GAP_W   = (gap_cycles_p > 32'd1) ? $clog2(gap_cycles_p) : 32'd1;
   localparam logic [INIT_W-1:0]      INIT_LAST = INIT_W'(reset_cycles_p - 32'd1);
   localparam logic [GAP_W-1:0]       GAP_LAST  = GAP_W'(gap_cycles_p - 32'd1);
   localparam logic [len_width_p-1:0] LEN_MAX   = len_width_p'(payload_width_p);

   tag_tx_state_e        r_state, w_state_next;
   logic [FRAME_W-1:0]   r_shift, w_shift_next;
   logic [TOT_W-1:0]     r_bit_idx, w_bit_idx_next;
   logic [TOT_W-1:0]     r_total, w_total_next;
   logic [INIT_W-1:0]    r_init_cnt, w_init_cnt_next;
   logic [GAP_W-1:0]     r_gap_cnt, w_gap_cnt_next;
   logic                 r_tdi, w_tdi_next;
   logic                 r_tms, w_tms_next;
   logic                 r_ready, w_ready_next;
   logic                 r_busy, w_busy_next;
   logic                 r_init_done, w_init_done_next;
   logic [15:0]          r_count, w_count_next;

   logic                   w_accept;
   logic                   w_bit_advance;
   logic                   w_last_bit;
   logic [len_width_p-1:0] w_len_clamped;
   logic [FRAME_W-1:0]     w_frame;
   logic [TOT_W-1:0]       w_total;

   assign w_accept      = v_i & r_ready;
   assign w_len_clamped = (len_i > LEN_MAX) ? LEN_MAX : len_i;
   // Whole frame is packed once so the shifter only ever shifts right.
   assign w_frame       = {payload_i, w_len_clamped, node_id_i, data_not_reset_i, 1'b1};
   assign w_total       = TOT_W'(frame_bits(node_id_width_p, len_width_p, 32'(w_len_clamped)));
   assign w_last_bit    = (r_bit_idx == (r_total - TOT_W'(1)));

   bsg_gateway_tag_bit_timer #(
      .bit_cycles_p (bit_cycles_p)
   ) u_bit_timer (
      .i_clk         (clk_i),
      .i_reset       (reset_i),
      .i_restart     (w_accept),
      .i_enable      (r_state == ST_SEND),
      .o_bit_advance (w_bit_advance)
   );

   // State and registered-output update.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state     <= ST_INIT;
         r_shift     <= {FRAME_W{1'b0}};
         r_bit_idx   <= {TOT_W{1'b0}};
         r_total     <= {TOT_W{1'b0}};
         r_init_cnt  <= {INIT_W{1'b0}};
         r_gap_cnt   <= {GAP_W{1'b0}};
         r_tdi       <= 1'b0;
         r_tms       <= 1'b1;
         r_ready     <= 1'b0;
         r_busy      <= 1'b0;
         r_init_done <= 1'b0;
         r_count     <= 16'd0;
      end else begin
         r_state     <= w_state_next;
         r_shift     <= w_shift_next;
         r_bit_idx   <= w_bit_idx_next;
         r_total     <= w_total_next;
         r_init_cnt  <= w_init_cnt_next;
         r_gap_cnt   <= w_gap_cnt_next;
         r_tdi       <= w_tdi_next;
         r_tms       <= w_tms_next;
         r_ready     <= w_ready_next;
         r_busy      <= w_busy_next;
         r_init_done <= w_init_done_next;
         r_count     <= w_count_next;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_INIT: w_state_next = (r_init_cnt == INIT_LAST) ? ST_IDLE : ST_INIT;
         ST_IDLE: w_state_next = w_accept ? ST_SEND : ST_IDLE;
         ST_SEND: w_state_next = (w_bit_advance && w_last_bit) ? ST_GAP : ST_SEND;
         ST_GAP:  w_state_next = (r_gap_cnt == GAP_LAST) ? ST_IDLE : ST_GAP;
         default: w_state_next = ST_INIT;
      endcase
   end

   // Next values of the datapath and of every output register.
   always_comb begin
      w_shift_next     = r_shift;
      w_bit_idx_next   = r_bit_idx;
      w_total_next     = r_total;
      w_init_cnt_next  = r_init_cnt;
      w_gap_cnt_next   = r_gap_cnt;
      w_count_next     = r_count;
      w_init_done_next = r_init_done;
      w_tdi_next       = 1'b0;
      w_tms_next       = (w_state_next == ST_INIT);
      w_ready_next     = (w_state_next == ST_IDLE);
      w_busy_next      = (w_state_next == ST_SEND) || (w_state_next == ST_GAP);
      case (r_state)
         ST_INIT: begin
            w_init_cnt_next  = r_init_cnt + INIT_W'(1);
            w_init_done_next = (w_state_next == ST_IDLE) ? 1'b1 : r_init_done;
         end
         ST_IDLE: begin
            if (w_accept) begin
               w_tdi_next     = w_frame[0];
               w_shift_next   = w_frame >> 1;
               w_bit_idx_next = {TOT_W{1'b0}};
               w_total_next   = w_total;
            end else begin
               w_tdi_next     = 1'b0;
            end
         end
         ST_SEND: begin
            if (w_bit_advance && w_last_bit) begin
               w_tdi_next     = 1'b0;
               w_gap_cnt_next = {GAP_W{1'b0}};
               w_count_next   = r_count + 16'd1;
            end else if (w_bit_advance) begin
               w_tdi_next     = r_shift[0];
               w_shift_next   = r_shift >> 1;
               w_bit_idx_next = r_bit_idx + TOT_W'(1);
            end else begin
               w_tdi_next     = r_tdi;
            end
         end
         ST_GAP: begin
            w_gap_cnt_next = r_gap_cnt + GAP_W'(1);
         end
         default: begin
            w_tdi_next = 1'b0;
         end
      endcase
   end

   assign ready_o     = r_ready;
   assign tag_tdi_o   = r_tdi;
   assign tag_tms_o   = r_tms;
   assign busy_o      = r_busy;
   assign init_done_o = r_init_done;
   assign pkt_count_o = r_count;

endmodule

// File: tb/tb_bsg_gateway_tag_packet_tx.sv
// Directed bench for bsg_gateway_tag_packet_tx: default instance plus a
// slow-bit instance (bit_cycles_p=3, short preamble) on separate valid lines.
module tb_bsg_gateway_tag_packet_tx;

   logic        clk;
   logic        reset_i;
   logic        v_i, v3_i;
   logic [4:0]  node_i;
   logic        dnr_i;
   logic [5:0]  len_i;
   logic [35:0] payload_i;

   logic        ready, tdi, tms, busy, init_done;
   logic [15:0] count;
   logic        ready3, tdi3, tms3, busy3, init_done3;
   logic [15:0] count3;

   int          n_vec;
   int          n_err;
   logic [15:0] exp_count;

   // Bit i of this vector is the i-th serial bit of node 3, dnr 1, len 4, payload 4'b1010.
   localparam logic [16:0] EXP17 = 17'b10100001000001111;

   bsg_gateway_tag_packet_tx dut (
      .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .node_id_i(node_i),
      .data_not_reset_i(dnr_i), .len_i(len_i), .payload_i(payload_i),
      .ready_o(ready), .tag_tdi_o(tdi), .tag_tms_o(tms), .busy_o(busy),
      .init_done_o(init_done), .pkt_count_o(count)
   );

   bsg_gateway_tag_packet_tx #(.reset_cycles_p(4), .bit_cycles_p(3)) dut3 (
      .clk_i(clk), .reset_i(reset_i), .v_i(v3_i), .node_id_i(node_i),
      .data_not_reset_i(dnr_i), .len_i(len_i), .payload_i(payload_i),
      .ready_o(ready3), .tag_tdi_o(tdi3), .tag_tms_o(tms3), .busy_o(busy3),
      .init_done_o(init_done3), .pkt_count_o(count3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference frame builder: start, dnr, node, clamped len, payload, each LSB first.
   function automatic void build_frame(input logic [4:0] node, input logic dnr, input logic [5:0] len,
                                       input logic [35:0] pl, output logic [63:0] bits, output int n);
      int lc;
      lc   = (int'(len) > 36) ? 36 : int'(len);
      bits = 64'd0;
      n    = 0;
      bits[n] = 1'b1; n++;
      bits[n] = dnr;  n++;
      for (int k = 0; k < 5; k++) begin bits[n] = node[k]; n++; end
      for (int k = 0; k < 6; k++) begin bits[n] = lc[k]; n++; end
      for (int k = 0; k < lc; k++) begin bits[n] = pl[k]; n++; end
   endfunction

   task automatic wait_ready;
      int k;
      k = 0;
      while (ready !== 1'b1 && k < 200) begin tick(); k++; end
      n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL wait_ready: got %b expected 1", ready); end
   endtask

   task automatic check_preamble(input string name);
      int n;
      n = 0;
      while (tms === 1'b1 && n < 200) begin
         n_vec++; if (init_done !== 1'b0) begin n_err++; $display("FAIL %s init_done early: got %b expected 0 at cycle %0d", name, init_done, n); end
         n++;
         tick();
      end
      n_vec++; if (n != 64)              begin n_err++; $display("FAIL %s tms cycles: got %0d expected 64", name, n); end
      n_vec++; if (init_done !== 1'b1)   begin n_err++; $display("FAIL %s init_done: got %b expected 1", name, init_done); end
      n_vec++; if (ready !== 1'b1)       begin n_err++; $display("FAIL %s ready: got %b expected 1", name, ready); end
      n_vec++; if (tdi !== 1'b0)         begin n_err++; $display("FAIL %s idle tdi: got %b expected 0", name, tdi); end
   endtask

   task automatic test_reset;
      reset_i = 1'b1; v_i = 1'b0; v3_i = 1'b0;
      node_i = 5'd0; dnr_i = 1'b0; len_i = 6'd0; payload_i = 36'd0;
      repeat (3) tick();
      n_vec++; if (ready !== 1'b0)      begin n_err++; $display("FAIL rst ready: got %b expected 0", ready); end
      n_vec++; if (tdi !== 1'b0)        begin n_err++; $display("FAIL rst tdi: got %b expected 0", tdi); end
      n_vec++; if (tms !== 1'b1)        begin n_err++; $display("FAIL rst tms: got %b expected 1", tms); end
      n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rst busy: got %b expected 0", busy); end
      n_vec++; if (init_done !== 1'b0)  begin n_err++; $display("FAIL rst init_done: got %b expected 0", init_done); end
      n_vec++; if (count !== 16'd0)     begin n_err++; $display("FAIL rst count: got %0d expected 0", count); end
      reset_i = 1'b0;
      check_preamble("preamble");
      n_vec++; if (init_done3 !== 1'b1) begin n_err++; $display("FAIL dut3 init_done: got %b expected 1", init_done3); end
      exp_count = 16'd0;
   endtask

   task automatic test_basic_frame;
      wait_ready();
      node_i = 5'd3; dnr_i = 1'b1; len_i = 6'd4; payload_i = 36'hA; v_i = 1'b1;
      tick();
      // Garbage with valid high while busy must be ignored.
      node_i = 5'h1C; dnr_i = 1'b0; len_i = 6'd9; payload_i = 36'hF_FFFF_FFF5;
      for (int i = 0; i < 17; i++) begin
         if (i == 5) v_i = 1'b0;
         n_vec++; if (tdi !== EXP17[i]) begin n_err++; $display("FAIL basic bit %0d: got %b expected %b", i, tdi, EXP17[i]); end
         n_vec++; if (busy !== 1'b1 || ready !== 1'b0 || tms !== 1'b0) begin n_err++; $display("FAIL basic flags bit %0d: got busy%b ready%b tms%b expected 1 0 0", i, busy, ready, tms); end
         tick();
      end
      exp_count++;
      for (int g = 0; g < 2; g++) begin
         n_vec++; if (tdi !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL basic gap %0d: got tdi%b busy%b expected 0 1", g, tdi, busy); end
         n_vec++; if (count !== exp_count) begin n_err++; $display("FAIL basic count: got %0d expected %0d", count, exp_count); end
         tick();
      end
      n_vec++; if (ready !== 1'b1 || busy !== 1'b0 || tdi !== 1'b0) begin n_err++; $display("FAIL basic idle: got ready%b busy%b tdi%b expected 1 0 0", ready, busy, tdi); end
      repeat (3) tick();
      n_vec++; if (count !== exp_count) begin n_err++; $display("FAIL basic no-extra count: got %0d expected %0d", count, exp_count); end
   endtask

   task automatic test_bit_cycles;
      int k;
      k = 0;
      while (ready3 !== 1'b1 && k < 50) begin tick(); k++; end
      n_vec++; if (ready3 !== 1'b1) begin n_err++; $display("FAIL slow ready: got %b expected 1", ready3); end
      node_i = 5'd3; dnr_i = 1'b1; len_i = 6'd4; payload_i = 36'hA; v3_i = 1'b1;
      tick();
      v3_i = 1'b0; payload_i = 36'h0;
      for (int i = 0; i < 17; i++) begin
         for (int j = 0; j < 3; j++) begin
            n_vec++; if (tdi3 !== EXP17[i]) begin n_err++; $display("FAIL slow bit %0d.%0d: got %b expected %b", i, j, tdi3, EXP17[i]); end
            tick();
         end
      end
      n_vec++; if (tdi3 !== 1'b0 || busy3 !== 1'b1) begin n_err++; $display("FAIL slow gap: got tdi%b busy%b expected 0 1", tdi3, busy3); end
      n_vec++; if (count3 !== 16'd1) begin n_err++; $display("FAIL slow count: got %0d expected 1", count3); end
   endtask

   task automatic test_clamp;
      logic [63:0] bits, got;
      int          n;
      logic [35:0] pl;
      pl = 36'hA_5F0C_3961;
      build_frame(5'd17, 1'b0, 6'd63, pl, bits, n);
      got = 64'd0;
      wait_ready();
      node_i = 5'd17; dnr_i = 1'b0; len_i = 6'd63; payload_i = pl; v_i = 1'b1;
      tick();
      v_i = 1'b0; node_i = 5'd0; dnr_i = 1'b1; len_i = 6'd0; payload_i = ~pl;
      for (int i = 0; i < n; i++) begin
         got[i] = tdi;
         n_vec++; if (tdi !== bits[i]) begin n_err++; $display("FAIL clamp bit %0d: got %b expected %b", i, tdi, bits[i]); end
         tick();
      end
      exp_count++;
      n_vec++; if (got[12:7] !== 6'd36) begin n_err++; $display("FAIL clamp len field: got %0d expected 36", got[12:7]); end
      n_vec++; if (tdi !== 1'b0 || count !== exp_count) begin n_err++; $display("FAIL clamp end: got tdi%b count%0d expected 0 %0d", tdi, count, exp_count); end

      build_frame(5'd9, 1'b1, 6'd0, pl, bits, n);
      wait_ready();
      node_i = 5'd9; dnr_i = 1'b1; len_i = 6'd0; payload_i = pl; v_i = 1'b1;
      tick();
      v_i = 1'b0;
      for (int i = 0; i < 13; i++) begin
         n_vec++; if (tdi !== bits[i]) begin n_err++; $display("FAIL len0 bit %0d: got %b expected %b", i, tdi, bits[i]); end
         tick();
      end
      exp_count++;
      n_vec++; if (tdi !== 1'b0 || busy !== 1'b1 || count !== exp_count) begin n_err++; $display("FAIL len0 end: got tdi%b busy%b count%0d expected 0 1 %0d", tdi, busy, count, exp_count); end
   endtask

   task automatic test_back_to_back;
      logic [63:0] bits;
      int          n;
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      check_preamble("b2b preamble");
      exp_count = 16'd0;
      build_frame(5'd2, 1'b1, 6'd3, 36'h5, bits, n);
      node_i = 5'd2; dnr_i = 1'b1; len_i = 6'd3; payload_i = 36'h5; v_i = 1'b1;
      tick();
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < n; i++) begin
            n_vec++; if (tdi !== bits[i] || ready !== 1'b0) begin n_err++; $display("FAIL b2b frame %0d bit %0d: got tdi%b ready%b expected %b 0", f, i, tdi, ready, bits[i]); end
            tick();
         end
         for (int g = 0; g < 3; g++) begin
            n_vec++; if (tdi !== 1'b0) begin n_err++; $display("FAIL b2b gap f%0d c%0d: got %b expected 0", f, g, tdi); end
            if (g == 0) begin
               n_vec++; if (count !== 16'(f + 1)) begin n_err++; $display("FAIL b2b count f%0d: got %0d expected %0d", f, count, f + 1); end
            end
            if (g == 2) begin
               n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b accept cycle f%0d: got %b expected 1", f, ready); end
               if (f == 2) v_i = 1'b0;
            end
            tick();
         end
      end
      exp_count = 16'd3;
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (tdi !== 1'b0 || ready !== 1'b1) begin n_err++; $display("FAIL b2b tail %0d: got tdi%b ready%b expected 0 1", i, tdi, ready); end
         tick();
      end
      n_vec++; if (count !== exp_count) begin n_err++; $display("FAIL b2b final count: got %0d expected %0d", count, exp_count); end
   endtask

   task automatic test_reset_mid;
      wait_ready();
      node_i = 5'd3; dnr_i = 1'b1; len_i = 6'd4; payload_i = 36'hA; v_i = 1'b1;
      tick();
      v_i = 1'b0;
      repeat (8) tick();
      n_vec++; if (tdi !== EXP17[8] || busy !== 1'b1) begin n_err++; $display("FAIL mid bit8: got tdi%b busy%b expected %b 1", tdi, busy, EXP17[8]); end
      reset_i = 1'b1;
      tick();
      n_vec++; if (tdi !== 1'b0 || tms !== 1'b1) begin n_err++; $display("FAIL mid abort pins: got tdi%b tms%b expected 0 1", tdi, tms); end
      n_vec++; if (count !== 16'd0) begin n_err++; $display("FAIL mid count: got %0d expected 0", count); end
      n_vec++; if (busy !== 1'b0 || ready !== 1'b0 || init_done !== 1'b0) begin n_err++; $display("FAIL mid flags: got busy%b ready%b init%b expected 0 0 0", busy, ready, init_done); end
      reset_i = 1'b0;
      check_preamble("mid replay");
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      exp_count = 16'd0;
      test_reset();
      test_basic_frame();
      test_bit_cycles();
      test_clamp();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
